// File: rtl/compa_search_ctrl_pkg.sv
// Shared types for the compa comparator search controller: FSM states, flag bundle,
// and the one-hot flag check.
package compa_search_ctrl_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        EVAL = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic lt;
        logic eq;
        logic gt;
    } cmp_flags_t;

    // A healthy comparator raises exactly one of lt/eq/gt.
    function automatic logic onehot3(input cmp_flags_t f);
        logic ok;
        case ({f.lt, f.eq, f.gt})
            3'b100:  ok = 1'b1;
            3'b010:  ok = 1'b1;
            3'b001:  ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/compa_search_ctrl_if.sv
// Handshake/bus bundle between the search controller and its comparator and result consumer.
interface compa_search_ctrl_if #(
    parameter int WIDTH = 4
);
    localparam int PW = $clog2(WIDTH + 2);

    logic             start;
    logic             busy;
    logic [WIDTH-1:0] cmp_b;
    logic             cmp_lt;
    logic             cmp_eq;
    logic             cmp_gt;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_value;
    logic             res_err;
    logic [PW-1:0]    res_probes;

    modport master (
        input  start, cmp_lt, cmp_eq, cmp_gt, res_ready,
        output busy, cmp_b, res_valid, res_value, res_err, res_probes
    );

    modport slave (
        output start, cmp_lt, cmp_eq, cmp_gt, res_ready,
        input  busy, cmp_b, res_valid, res_value, res_err, res_probes
    );

endinterface

// File: rtl/compa_search_ctrl.sv
// Binary-search initiator: drives probe b into a comparator against an unknown target a
// and walks the interval on lt/gt until eq, then presents the target via valid/ready.
module compa_search_ctrl
    import compa_search_ctrl_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int CMP_LAT = 0
) (
    input  logic                clk,
    input  logic                rst,
    compa_search_ctrl_if.master bus
);

    localparam int IW = WIDTH + 1;
    localparam int PW = $clog2(WIDTH + 2);

    localparam logic [IW-1:0]    HI_INIT  = IW'((1 << WIDTH) - 1);
    localparam logic [WIDTH-1:0] MID_INIT = WIDTH'(((1 << WIDTH) - 1) >> 1);
    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(CMP_LAT);

    state_t           state_r;
    logic [IW-1:0]    lo_r;
    logic [IW-1:0]    hi_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] cmp_b_r;
    logic             busy_r;
    logic             res_valid_r;
    logic [WIDTH-1:0] res_value_r;
    logic             res_err_r;
    logic [PW-1:0]    res_probes_r;

    cmp_flags_t       flags_s;
    logic [IW-1:0]    probe_ext_s;
    logic [IW-1:0]    next_lo_s;
    logic [IW-1:0]    next_hi_s;
    logic [WIDTH-1:0] next_mid_s;
    logic             empty_s;

    assign flags_s     = cmp_flags_t'({bus.cmp_lt, bus.cmp_eq, bus.cmp_gt});
    assign probe_ext_s = {1'b0, cmp_b_r};

    // Next interval after a lt/gt verdict; emptiness is tested before the +/-1 so mid=0 cannot wrap.
    always_comb begin
        next_lo_s = lo_r;
        next_hi_s = hi_r;
        empty_s   = 1'b0;
        if (flags_s.lt) begin
            if (probe_ext_s <= lo_r) begin
                empty_s = 1'b1;
            end else begin
                next_hi_s = probe_ext_s - IW'(1);
            end
        end else if (flags_s.gt) begin
            if (probe_ext_s >= hi_r) begin
                empty_s = 1'b1;
            end else begin
                next_lo_s = probe_ext_s + IW'(1);
            end
        end else begin
            empty_s = 1'b0;
        end
        next_mid_s = WIDTH'((next_lo_s + next_hi_s) >> 1);
    end

    // Search FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            lo_r         <= '0;
            hi_r         <= '0;
            cnt_r        <= '0;
            cmp_b_r      <= '0;
            busy_r       <= 1'b0;
            res_valid_r  <= 1'b0;
            res_value_r  <= '0;
            res_err_r    <= 1'b0;
            res_probes_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        lo_r         <= '0;
                        hi_r         <= HI_INIT;
                        res_probes_r <= '0;
                        cmp_b_r      <= MID_INIT;
                        cnt_r        <= LAT_INIT;
                        busy_r       <= 1'b1;
                        state_r      <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_r == '0) begin
                        state_r <= EVAL;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                EVAL: begin
                    res_probes_r <= res_probes_r + PW'(1);
                    if (!onehot3(flags_s) || flags_s.eq || empty_s) begin
                        // On eq this is the target; on failure it is the last probe.
                        res_value_r <= cmp_b_r;
                        res_err_r   <= !(onehot3(flags_s) && flags_s.eq);
                        res_valid_r <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= DONE;
                    end else begin
                        lo_r    <= next_lo_s;
                        hi_r    <= next_hi_s;
                        cmp_b_r <= next_mid_s;
                        cnt_r   <= LAT_INIT;
                        state_r <= WAIT;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        res_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    busy_r      <= 1'b0;
                    res_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = busy_r;
    assign bus.cmp_b      = cmp_b_r;
    assign bus.res_valid  = res_valid_r;
    assign bus.res_value  = res_value_r;
    assign bus.res_err    = res_err_r;
    assign bus.res_probes = res_probes_r;

endmodule

// File: tb/tb_compa_search_ctrl.sv
// Directed bench: two controllers (CMP_LAT 0 and 3) each bound to a behavioural 4-bit comparator.
module tb_compa_search_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] a0, a3;
    logic       force0, force3;

    compa_search_ctrl_if #(.WIDTH(4)) if0 ();
    compa_search_ctrl_if #(.WIDTH(4)) if3 ();

    // Comparator models; the force flags inject an illegal lt=gt=1 pattern.
    assign if0.cmp_lt = force0 | (a0 < if0.cmp_b);
    assign if0.cmp_eq = ~force0 & (a0 == if0.cmp_b);
    assign if0.cmp_gt = force0 | (a0 > if0.cmp_b);
    assign if3.cmp_lt = force3 | (a3 < if3.cmp_b);
    assign if3.cmp_eq = ~force3 & (a3 == if3.cmp_b);
    assign if3.cmp_gt = force3 | (a3 > if3.cmp_b);

    compa_search_ctrl #(.WIDTH(4), .CMP_LAT(0)) dut0 (.clk(clk), .rst(rst), .bus(if0.master));
    compa_search_ctrl #(.WIDTH(4), .CMP_LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(if3.master));

    int checks = 0;
    int errors = 0;
    int seq_q[$];
    int len_q[$];

    task automatic pulse_start(input int sel);
        @(negedge clk);
        if (sel == 0) if0.start = 1'b1;
        else          if3.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        if3.start = 1'b0;
    endtask

    // Records the probe sequence and per-probe hold lengths until res_valid or the cycle budget runs out.
    task automatic run_wait(input int sel, input int clr_at, input int chg_a, output bit to);
        bit         pb;
        int         lb;
        logic       bz, v;
        logic [3:0] b;
        pb = 1'b0; lb = -1; to = 1'b1;
        seq_q.delete(); len_q.delete();
        for (int i = 0; i < 200; i++) begin
            bz = (sel == 0) ? if0.busy : if3.busy;
            b  = (sel == 0) ? if0.cmp_b : if3.cmp_b;
            v  = (sel == 0) ? if0.res_valid : if3.res_valid;
            if (bz) begin
                if (!pb || int'(b) != lb) begin
                    seq_q.push_back(int'(b));
                    len_q.push_back(1);
                end else begin
                    len_q[len_q.size()-1] = len_q[len_q.size()-1] + 1;
                end
            end
            pb = bz; lb = int'(b);
            if (i == clr_at) begin force0 = 1'b0; force3 = 1'b0; end
            if (chg_a >= 0 && seq_q.size() == 2) a0 = 4'(chg_a);
            if (v) begin to = 1'b0; break; end
            @(negedge clk);
        end
    endtask

    task automatic ack();
        @(negedge clk);
        if0.res_ready = 1'b1; if3.res_ready = 1'b1;
        @(negedge clk);
        if0.res_ready = 1'b0; if3.res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; a0 = 4'd0; a3 = 4'd0; force0 = 1'b0; force3 = 1'b0;
        if0.start = 1'b0; if3.start = 1'b0; if0.res_ready = 1'b0; if3.res_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (if0.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", if0.busy); end
        checks++; if (if0.res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", if0.res_valid); end
        checks++; if (if0.res_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", if0.res_err); end
        checks++; if (if0.cmp_b !== 4'd0) begin errors++; $display("FAIL reset_cmp_b: got %0d expected 0", if0.cmp_b); end
        checks++; if (if0.res_value !== 4'd0) begin errors++; $display("FAIL reset_value: got %0d expected 0", if0.res_value); end
        checks++; if (if0.res_probes !== 3'd0) begin errors++; $display("FAIL reset_probes: got %0d expected 0", if0.res_probes); end
        checks++; if (if3.busy !== 1'b0 || if3.cmp_b !== 4'd0) begin errors++; $display("FAIL reset_dut3: got busy %b cmp_b %0d expected 0 0", if3.busy, if3.cmp_b); end
    endtask

    task automatic test_search(input logic [3:0] a, input int exp_n, input logic [19:0] exp_seq);
        bit to;
        a0 = a;
        pulse_start(0);
        run_wait(0, -1, -1, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL search_timeout a=%0d: got timeout expected result", a); end
        checks++; if (seq_q.size() != exp_n) begin errors++; $display("FAIL search_nprobe a=%0d: got %0d expected %0d", a, seq_q.size(), exp_n); end
        for (int k = 0; k < exp_n && k < seq_q.size(); k++) begin
            checks++;
            if (seq_q[k] != int'(exp_seq[k*4 +: 4])) begin
                errors++; $display("FAIL search_probe a=%0d idx %0d: got %0d expected %0d", a, k, seq_q[k], exp_seq[k*4 +: 4]);
            end
        end
        checks++; if (if0.res_value !== a) begin errors++; $display("FAIL search_value: got %0d expected %0d", if0.res_value, a); end
        checks++; if (if0.res_err !== 1'b0) begin errors++; $display("FAIL search_err a=%0d: got %b expected 0", a, if0.res_err); end
        checks++; if (if0.res_probes !== 3'(exp_n)) begin errors++; $display("FAIL search_probes a=%0d: got %0d expected %0d", a, if0.res_probes, exp_n); end
        ack();
        checks++; if (if0.res_valid !== 1'b0) begin errors++; $display("FAIL search_handshake a=%0d: got valid %b expected 0", a, if0.res_valid); end
    endtask

    task automatic test_latency();
        bit to;
        a3 = 4'd5; force3 = 1'b1;
        pulse_start(3);
        run_wait(3, 3, -1, to);
        force3 = 1'b0;
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL lat_timeout: got timeout expected result"); end
        checks++; if (seq_q.size() != 3) begin errors++; $display("FAIL lat_nprobe: got %0d expected 3", seq_q.size()); end
        for (int k = 0; k < 3 && k < seq_q.size(); k++) begin
            checks++; if (len_q[k] != 5) begin errors++; $display("FAIL lat_hold idx %0d: got %0d cycles expected 5", k, len_q[k]); end
        end
        checks++; if (seq_q.size() > 1 && seq_q[1] != 3) begin errors++; $display("FAIL lat_probe2: got %0d expected 3", seq_q[1]); end
        checks++; if (if3.res_value !== 4'd5 || if3.res_err !== 1'b0) begin errors++; $display("FAIL lat_result: got %0d err %b expected 5 err 0", if3.res_value, if3.res_err); end
        checks++; if (if3.res_probes !== 3'd3) begin errors++; $display("FAIL lat_probes: got %0d expected 3", if3.res_probes); end
        ack();
    endtask

    task automatic test_bad_flags();
        bit to;
        a0 = 4'd9; force0 = 1'b1;
        pulse_start(0);
        run_wait(0, -1, -1, to);
        force0 = 1'b0;
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL bad_timeout: got timeout expected result"); end
        checks++; if (if0.res_err !== 1'b1) begin errors++; $display("FAIL bad_err: got %b expected 1", if0.res_err); end
        checks++; if (if0.res_value !== 4'd7) begin errors++; $display("FAIL bad_value: got %0d expected 7", if0.res_value); end
        checks++; if (if0.res_probes !== 3'd1) begin errors++; $display("FAIL bad_probes: got %0d expected 1", if0.res_probes); end
        ack();
    endtask

    task automatic test_collapse();
        bit to;
        a0 = 4'd11;
        pulse_start(0);
        run_wait(0, -1, 2, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL collapse_timeout: got timeout expected result"); end
        checks++; if (if0.res_err !== 1'b1) begin errors++; $display("FAIL collapse_err: got %b expected 1", if0.res_err); end
        checks++; if (if0.res_value !== 4'd8) begin errors++; $display("FAIL collapse_value: got %0d expected 8", if0.res_value); end
        checks++; if (if0.res_probes !== 3'd4) begin errors++; $display("FAIL collapse_probes: got %0d expected 4", if0.res_probes); end
        ack();
    endtask

    task automatic test_back_to_back();
        bit to;
        a0 = 4'd6;
        pulse_start(0);
        run_wait(0, -1, -1, to);
        checks++; if (to !== 1'b0 || if0.res_value !== 4'd6 || if0.res_probes !== 3'd4) begin
            errors++; $display("FAIL hold_result: got value %0d probes %0d expected 6 4", if0.res_value, if0.res_probes);
        end
        if0.start = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (if0.res_valid !== 1'b1 || if0.res_value !== 4'd6 || if0.busy !== 1'b0) begin
                errors++; $display("FAIL hold_stable cycle %0d: got valid %b value %0d busy %b expected 1 6 0", c, if0.res_valid, if0.res_value, if0.busy);
            end
        end
        if0.start = 1'b0;
        @(negedge clk);
        if0.res_ready = 1'b1;
        @(negedge clk);
        if0.res_ready = 1'b0;
        if0.start = 1'b1;
        checks++; if (if0.res_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_drop: got %b expected 0", if0.res_valid); end
        @(negedge clk);
        if0.start = 1'b0;
        checks++; if (if0.busy !== 1'b1) begin errors++; $display("FAIL b2b_restart: got busy %b expected 1", if0.busy); end
        run_wait(0, -1, -1, to);
        checks++; if (to !== 1'b0 || if0.res_value !== 4'd6) begin errors++; $display("FAIL b2b_second: got value %0d timeout %b expected 6 0", if0.res_value, to); end
        ack();
    endtask

    task automatic test_rst_mid();
        a3 = 4'd5;
        pulse_start(3);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (if3.busy !== 1'b0 || if3.res_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_state: got busy %b valid %b expected 0 0", if3.busy, if3.res_valid); end
        checks++; if (if3.cmp_b !== 4'd0 || if3.res_probes !== 3'd0) begin errors++; $display("FAIL rst_mid_regs: got cmp_b %0d probes %0d expected 0 0", if3.cmp_b, if3.res_probes); end
        repeat (8) @(negedge clk);
        checks++; if (if3.res_valid !== 1'b0 || if3.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_noresult: got valid %b busy %b expected 0 0", if3.res_valid, if3.busy); end
    endtask

    initial begin
        test_reset();
        test_search(4'd11, 2, {4'd0, 4'd0, 4'd0, 4'd11, 4'd7});
        test_search(4'd0, 4, {4'd0, 4'd0, 4'd1, 4'd3, 4'd7});
        test_search(4'd15, 5, {4'd15, 4'd14, 4'd13, 4'd11, 4'd7});
        test_search(4'd8, 4, {4'd0, 4'd8, 4'd9, 4'd11, 4'd7});
        test_latency();
        test_bad_flags();
        test_collapse();
        test_back_to_back();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
